lsu_byte_sequencer: RTL

Load/store initiator for the data memory in the pipelined core's MEM stage. It accepts one load or store request at a time from the pipeline and decomposes it into single-byte memory accesses, issued one per cycle. For loads it reassembles the bytes into a little-endian word and applies RISC-V sign or zero extension. This gives consistent byte ordering and arbitrary alignment, independent of the memory's native word and halfword modes.

---
 rtl/lsu_byte_sequencer_if.sv | 25 ++
 rtl/lsu_byte_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lsu_byte_sequencer_if.sv
// Request/response bundle between the MEM stage and lsu_byte_sequencer.
// master = pipeline side, slave = sequencer side.
interface lsu_byte_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store initiator: one memory byte per cycle, LE reassembly.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word requests.
module lsu_byte_sequencer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] MMIO_ADDR = 32'h100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lsu_byte_sequencer_if.slave   bus,
    output logic [2:0]            mem_mode,
    output logic [WIDTH-1:0]      mem_addr,
    output logic [WIDTH-1:0]      mem_wd,
    output logic                  mem_we,
    input  logic [WIDTH-1:0]      mem_rd
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       last_q, last_d;
    logic             mmio_q, mmio_d;
    logic             err_q, err_d;

    logic             legal;
    logic             misal;
    logic             xfer;
    logic [WIDTH-1:0] ext;

    always_comb begin
        legal = 1'b0;
        if (bus.req_we) begin
            legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                    (bus.req_funct3 == 3'b010);
        end else begin
            legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                    (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                    (bus.req_funct3 == 3'b101);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        last_d  = last_q;
        mmio_d  = mmio_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    buf_d   = '0;
                    idx_d   = 2'd0;
                    mmio_d  = (bus.req_addr == MMIO_ADDR);
                    err_d   = !legal || misal;
                    last_d  = bus.req_funct3[1] ? 2'd3 :
                              (bus.req_funct3[0] ? 2'd1 : 2'd0);
                    // MMIO loads are a single full-width read
                    if (mmio_d) last_d = 2'd0;
                    if (err_d || (mmio_d && bus.req_we)) state_d = RESP;
                    else                                  state_d = XFER;
                end
            end
            XFER: begin
                if (!we_q) begin
                    if (mmio_q) buf_d = mem_rd;
                    else        buf_d[{idx_q, 3'b000} +: 8] = mem_rd[7:0];
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == last_q) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            mmio_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            mmio_q  <= mmio_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        ext = buf_q;
        if (!mmio_q) begin
            case (f3_q)
                3'b000:  ext = {{(WIDTH-8){buf_q[7]}}, buf_q[7:0]};
                3'b001:  ext = {{(WIDTH-16){buf_q[15]}}, buf_q[15:0]};
                3'b100:  ext = {{(WIDTH-8){1'b0}}, buf_q[7:0]};
                3'b101:  ext = {{(WIDTH-16){1'b0}}, buf_q[15:0]};
                default: ext = buf_q;
            endcase
        end
    end

    assign xfer = (state_q == XFER);

    always_comb begin
        mem_mode = 3'b000;
        mem_addr = '0;
        mem_wd   = '0;
        mem_we   = 1'b0;
        if (xfer) begin
            mem_addr = addr_q + WIDTH'(idx_q);
            if (we_q) begin
                mem_mode = 3'b011;
                mem_we   = 1'b1;
                mem_wd   = {{(WIDTH-8){1'b0}}, wdata_q[{idx_q, 3'b000} +: 8]};
            end else begin
                mem_mode = mmio_q ? 3'b001 : 3'b101;
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ext : '0;

endmodule
